hex_display_scanner: RTL and testbench
======================================

Name: hex_display_scanner

Overview:
Time-multiplexed driver for a bank of common-anode 7-segment digits. It sits between the processor's output port and the board's display pins, with one hex-to-segment decode shared across all digits. The block:
- holds one 4-bit nibble per digit, written through a req/ack handshake;
- sequences digit enables with a refresh divider and an anti-ghosting guard slot;
- registers the shared decode result before it reaches the pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- ADDR_W, 2: write-address width; must be >= clog2(NUM_DIGITS).
- DIV_COUNT, 49999: DRIVE slot lasts DIV_COUNT+1 clocks.
- GUARD_CYCLES, 4: clocks with all anodes off between digits (>=1).

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- wr_req  in  1  write request; held high until wr_ack is seen.
- wr_addr  in  ADDR_W  digit index to write.
- wr_data  in  4  hex nibble to store.
- wr_ack  out  1  one-cycle write acknowledge.
- blank_mask  in  NUM_DIGITS  bit i=1 forces digit i dark.
- an  out  NUM_DIGITS  anode enables, active-low, at most one low.
- seg  out  7  segments a..g, active-low, seg[6]=a ... seg[0]=g.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (Resetn low, asynchronous) forces:
  - digit buffer all 0; idx=0; state=GUARD; divider and guard counters=0;
  - an=all 1s, seg=7'h7F, wr_ack=0, frame_done=0.
- Reset mid-frame or mid-handshake aborts immediately. A write not yet acked is lost; the requester re-issues it.
- Write handshake:
  - wr_req is sampled on a rising edge only while wr_ack=0.
  - On that edge: buffer[wr_addr]<=wr_data and wr_ack<=1.
  - Next edge: wr_ack<=0 unconditionally. Maximum write rate is therefore one per 2 clocks.
  - wr_addr >= NUM_DIGITS: acked with no buffer change.
- Refresh FSM, two states:
  - GUARD: an=all 1s and the guard counter counts 0..GUARD_CYCLES-1. At GUARD_CYCLES-1 → DRIVE, divider cleared.
  - DRIVE: an[idx]=0 unless blank_mask[idx]=1. The divider counts 0..DIV_COUNT. At DIV_COUNT → GUARD and idx advances.
  - idx wraps NUM_DIGITS-1 → 0. On that wrap edge frame_done=1 for exactly one cycle.
  - Frame length = NUM_DIGITS*(DIV_COUNT+1+GUARD_CYCLES) clocks.
- Decode:
  - seg is registered from buffer[idx] every clock, giving 1-cycle latency from any idx or buffer change.
  - seg=7'h7F whenever state=GUARD, and in DRIVE when blank_mask[idx]=1.
- Hex table, active-low, 0..F:
  - 0: 01,4F,12,06 (0-3)
  - 4C,24,20,0F (4-7)
  - 00,04,08,60 (8-B)
  - 31,42,30,38 (C-F)
- Simultaneous events: a write to buffer[idx] during DRIVE shows the new seg on the clock after the ack edge. A write and a slot change on the same edge are independent.
- blank_mask is sampled combinationally into the registered an/seg, with no extra latency.

Optional Feature:
HEX_SCAN_LZ_BLANK_EN
- Defined: during DRIVE, digit i>0 is also dark when buffer[i..NUM_DIGITS-1] are all 0, giving leading-zero suppression. Digit 0 is never suppressed, so value 0 shows "0".
- Not defined: all digits display as written; blank_mask is the only blanking source.

Test Plan:
Common setup: DIV_COUNT=3, GUARD_CYCLES=1, NUM_DIGITS=4.
- Reset release → an=4'hF, seg=7'h7F for 1 clk, then an=4'hE for 4 clks with seg=7'h01; frame_done every 20 clks.
- Write addr 2 data 4'hA, req held → wr_ack high exactly 1 clk after req sampled. In digit-2 slot: an=4'hB, seg=7'h08.
- Req held high through 3 writes → acks spaced 2 clks apart; the 4th req beat waits for ack low.
- blank_mask=4'b0010 → during slot 1, an=4'hF and seg=7'h7F; other slots unaffected.
- Write addr 0 data 4'h7 mid-slot 0 → seg changes 7'h01→7'h0F one clk after the ack edge. wr_addr=5 (ADDR_W=3) → acked, no buffer change.
- Resetn low mid-DRIVE of digit 3 → an=4'hF, seg=7'h7F and buffer=0 without waiting for a clock edge. With HEX_SCAN_LZ_BLANK_EN and buffer={0,0,3,0} (digit 3..0), digits 3 and 2 stay dark.

Source files
------------

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed driver for NUM_DIGITS common-anode
// 7-segment digits. It holds one nibble per digit, written over a req/ack
// handshake. A GUARD/DRIVE refresh FSM scans the digits. One shared hex
// decoder feeds registered an/seg outputs.
// Optional build macro: HEX_SCAN_LZ_BLANK_EN adds leading-zero suppression
// for digits above digit 0.
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int ADDR_W       = 2,
  parameter int DIV_COUNT    = 49999,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [3:0]            wr_data,
  output logic                  wr_ack,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int DIV_W = (DIV_COUNT > 0) ? $clog2(DIV_COUNT + 1) : 1;
  localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV_COUNT);
  localparam logic [GRD_W-1:0]  GRD_LAST = GRD_W'(GUARD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_GUARD, ST_DRIVE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       idx, idx_nxt;
  logic [DIV_W-1:0]        div_cnt, div_nxt;
  logic [GRD_W-1:0]        grd_cnt, grd_nxt;
  logic                    frame_nxt;
  logic [3:0]              digit_buf [NUM_DIGITS];
  logic [3:0]              cur_nib;
  logic                    cur_dark;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [6:0]              seg_nxt;

  // Active-low segment pattern (seg[6]=a ... seg[0]=g) for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

`ifdef HEX_SCAN_LZ_BLANK_EN
  // A digit above 0 goes dark when it and every more significant digit are 0.
  always_comb begin
    logic upper_zero;
    lz_dark    = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (digit_buf[i] == 4'h0);
      lz_dark[i] = upper_zero;
    end
  end
`else
  assign lz_dark = '0;
`endif

  // Select the nibble and blanking of the digit currently addressed by idx.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dark   = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == ADDR_W'(i)) begin
        cur_nib       = digit_buf[i];
        cur_dark      = blank_mask[i] | lz_dark[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Refresh FSM next state plus the an/seg/frame_done values to register.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    div_nxt   = div_cnt;
    grd_nxt   = grd_cnt;
    frame_nxt = 1'b0;
    an_nxt    = '1;
    seg_nxt   = 7'h7F;
    case (state)
      ST_GUARD: begin
        if (grd_cnt == GRD_LAST) begin
          state_nxt = ST_DRIVE;
          grd_nxt   = '0;
          div_nxt   = '0;
        end else begin
          grd_nxt = grd_cnt + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!cur_dark) begin
          an_nxt  = ~sel_onehot;
          seg_nxt = hex_to_seg(cur_nib);
        end
        if (div_cnt == DIV_LAST) begin
          state_nxt = ST_GUARD;
          grd_nxt   = '0;
          div_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            frame_nxt = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_GUARD;
    endcase
  end

  // FSM state, digit index and slot counters.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= ST_GUARD;
      idx     <= '0;
      div_cnt <= '0;
      grd_cnt <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      div_cnt <= div_nxt;
      grd_cnt <= grd_nxt;
    end
  end

  // Registered pin drivers: the decode lands on the pins one clock later.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      an         <= '1;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= frame_nxt;
    end
  end

  // Write handshake: accept only while ack is low, so the ack is one cycle
  // and back-to-back writes from a held request are two clocks apart.
  // Out-of-range addresses are acknowledged without touching the buffer.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ack <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= 4'h0;
    end else if (wr_ack) begin
      wr_ack <= 1'b0;
    end else if (wr_req) begin
      wr_ack <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_addr == ADDR_W'(i)) digit_buf[i] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Testbench for hex_display_scanner. A driver predicts each clock's
// outputs from a frame-position model and queues them. A monitor compares
// the queued values against the pins on the falling edge.
module tb_hex_display_scanner;

  localparam int N     = 4;
  localparam int AW    = 3;
  localparam int DIVC  = 3;
  localparam int GC    = 1;
  localparam int SLOT  = GC + DIVC + 1;
  localparam int FRAME = N * SLOT;

  logic          Clock;
  logic          Resetn;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_ack;
  logic [N-1:0]  blank_mask;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          frame_done;

  hex_display_scanner #(
    .NUM_DIGITS(N), .ADDR_W(AW), .DIV_COUNT(DIVC), .GUARD_CYCLES(GC)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .blank_mask(blank_mask),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         fd;
    logic         ack;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         c        = 0;
  logic [3:0] mbuf [N];
  logic       ack_m    = 1'b0;
  int         keep     = 0;
  logic [6:0] hex_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit lz_model(input int d);
`ifdef HEX_SCAN_LZ_BLANK_EN
    if (d == 0) return 1'b0;
    for (int k = d; k < N; k++) if (mbuf[k] != 4'h0) return 1'b0;
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  // Called right after a rising edge: inputs still hold the values the DUT sampled.
  task automatic predict();
    exp_t e;
    int p, d, r;
    bit dark;
    if (!Resetn) begin
      e.an = '1; e.seg = 7'h7F; e.fd = 1'b0; e.ack = 1'b0;
      c = 0; ack_m = 1'b0;
      for (int k = 0; k < N; k++) mbuf[k] = 4'h0;
    end else begin
      c++;
      e.ack = wr_req && !ack_m;
      p = (c - 1) % FRAME;
      d = p / SLOT;
      r = p % SLOT;
      dark = (r < GC) || blank_mask[d] || lz_model(d);
      e.an  = dark ? {N{1'b1}} : ~(4'b0001 << d);
      e.seg = dark ? 7'h7F : hex_tab[mbuf[d]];
      e.fd  = ((c % FRAME) == 0);
      if (e.ack && (wr_addr < AW'(N))) mbuf[wr_addr[1:0]] = wr_data;
      ack_m = e.ack;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clock);
    predict();
    #1;
  endtask

  // Requester that holds wr_req until the write is acknowledged.
  task automatic rand_req();
    if (wr_req && ack_m) begin
      if (keep > 0) begin
        keep--;
        wr_addr = AW'($urandom_range(0, 7));
        wr_data = 4'($urandom);
      end else begin
        wr_req = 1'b0;
      end
    end else if (!wr_req && ($urandom_range(0, 3) == 0)) begin
      wr_req  = 1'b1;
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = 4'($urandom);
      keep    = $urandom_range(0, 2);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] dat);
    wr_req = 1'b1; wr_addr = a; wr_data = dat;
    for (int k = 0; k < 4 && !ack_m; k++) tick();
    check("write_acked", 32'(ack_m), 32'd1);
    wr_req = 1'b0;
  endtask

  task automatic async_reset_check();
    @(negedge Clock); #1;
    Resetn = 1'b0; wr_req = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_ack", 32'(wr_ack), 32'd0);
    check("async_rst_fd", 32'(frame_done), 32'd0);
  endtask

  // Monitor: compare every presented cycle with the predicted values.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an", 32'(an), 32'(e.an));
        check("seg", 32'(seg), 32'(e.seg));
        check("frame_done", 32'(frame_done), 32'(e.fd));
        check("wr_ack", 32'(wr_ack), 32'(e.ack));
      end
    end
  end

  initial begin
    Resetn = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; blank_mask = '0;
    for (int k = 0; k < N; k++) mbuf[k] = 4'h0;
    repeat (3) tick();
    Resetn = 1'b1;

    // Startup pattern and the first frame_done pulse.
    repeat (3) tick();
    do_write(3'd0, 4'h7);
    do_write(3'd5, 4'h9);
    repeat (22) tick();

    // Single write then a held request through three writes.
    do_write(3'd2, 4'hA);
    wr_req = 1'b1; wr_addr = 3'd1; wr_data = 4'h3; keep = 2;
    for (int k = 0; k < 12 && wr_req; k++) begin
      tick();
      if (ack_m) begin
        if (keep > 0) begin
          keep--; wr_addr = (keep == 1) ? 3'd3 : 3'd6; wr_data = 4'hC;
        end else begin
          wr_req = 1'b0;
        end
      end
    end
    repeat (25) tick();

    // Blanking of digit 1 for a full frame.
    blank_mask = 4'b0010;
    repeat (22) tick();
    blank_mask = 4'b0000;

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      tick();
      rand_req();
      if ($urandom_range(0, 15) == 0) blank_mask = N'($urandom);
    end
    blank_mask = '0;

    // Reset while digit 3 is being driven.
    for (int k = 0; k < 2 * FRAME && (c % FRAME) != 18; k++) tick();
    async_reset_check();
    repeat (2) tick();
    Resetn = 1'b1;
    repeat (FRAME + 2) tick();

    for (int k = 0; k < 200; k++) begin
      tick();
      rand_req();
      if ($urandom_range(0, 15) == 0) blank_mask = N'($urandom);
    end

    @(negedge Clock); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
